sprite_attr_table: RTL and testbench



---
 rtl/sprite_attr_table_if.sv | 25 ++
 rtl/sprite_attr_table.sv | 132 +++++++++++++
 tb/tb_sprite_attr_table.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sprite_attr_table_if.sv
// Bus bundle between the CPU store port / renderer read port and the sprite attribute table.
// master = CPU and renderer side, slave = the table itself.
interface sprite_attr_table_if #(
  parameter int IDX_W  = 5,
  parameter int ADDR_W = 27
);
  logic [IDX_W-1:0]  i_sprite_idx;
  logic              i_rd_en;
  logic [63:0]       o_sprite_struct;
  logic              o_rd_valid;
  logic [31:0]       i_wdata;
  logic              i_wea;
  logic [3:0]        i_wselect;
  logic [ADDR_W-1:0] i_waddr;

  modport master (
    output i_sprite_idx, i_rd_en, i_wdata, i_wea, i_wselect, i_waddr,
    input  o_sprite_struct, o_rd_valid
  );

  modport slave (
    input  i_sprite_idx, i_rd_en, i_wdata, i_wea, i_wselect, i_waddr,
    output o_sprite_struct, o_rd_valid
  );
endinterface

// File: rtl/sprite_attr_table.sv
// Double-buffered sprite attribute table: CPU writes a shadow bank, a frame-start-triggered
// copy engine moves it into the active bank one entry per cycle, renderer reads the active bank.
module sprite_attr_table #(
  parameter int                SPRITE_COUNT = 32,
  parameter int                IDX_W        = 5,
  parameter int                ADDR_W       = 27,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 27'h100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sprite_attr_table_if.slave        bus,
  input  logic                      i_frame_start,
  output logic                      o_commit_pending,
  output logic                      o_busy
);

  typedef enum logic {IDLE, COPY} state_e;

  localparam logic [ADDR_W-1:0] TABLE_BYTES = ADDR_W'(8 * SPRITE_COUNT);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(SPRITE_COUNT - 1);

  logic [31:0] shadow_w0_q [SPRITE_COUNT];
  logic [31:0] shadow_w1_q [SPRITE_COUNT];
  logic [31:0] shadow_w0_d [SPRITE_COUNT];
  logic [31:0] shadow_w1_d [SPRITE_COUNT];
  logic [31:0] active_w0_q [SPRITE_COUNT];
  logic [31:0] active_w1_q [SPRITE_COUNT];
  logic [31:0] active_w0_d [SPRITE_COUNT];
  logic [31:0] active_w1_d [SPRITE_COUNT];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             rd_valid_q, rd_valid_d;
  logic [63:0]      sprite_q, sprite_d;

  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  wr_entry;
  logic              wr_word;
  logic              wr_table;
  logic              commit_req;

  function automatic logic [63:0] pack_struct(input logic [31:0] w0, input logic [31:0] w1);
    return {16'h0, w1[23:16], w1[31:24], w0[15:0], w0[31:16]};
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] sel);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Address decode: offset wraps modulo 2^ADDR_W, so addresses below BASE_ADDR fall out of range.
  always_comb begin
    off        = bus.i_waddr - BASE_ADDR;
    wr_entry   = off[IDX_W+2:3];
    wr_word    = off[2];
    wr_table   = bus.i_wea && (off < TABLE_BYTES);
    commit_req = bus.i_wea && (off == TABLE_BYTES) && bus.i_wselect[0] && bus.i_wdata[0];
  end

  always_comb begin
    shadow_w0_d = shadow_w0_q;
    shadow_w1_d = shadow_w1_q;
    active_w0_d = active_w0_q;
    active_w1_d = active_w1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q | commit_req;
    rd_valid_d  = bus.i_rd_en;
    sprite_d    = sprite_q;

    if (wr_table) begin
      if (wr_word) shadow_w1_d[wr_entry] = merge_bytes(shadow_w1_q[wr_entry], bus.i_wdata, bus.i_wselect);
      else         shadow_w0_d[wr_entry] = merge_bytes(shadow_w0_q[wr_entry], bus.i_wdata, bus.i_wselect);
    end

    // Read and copy both use registered banks: reads see pre-copy data, copies see pre-write shadow.
    if (bus.i_rd_en) sprite_d = pack_struct(active_w0_q[bus.i_sprite_idx], active_w1_q[bus.i_sprite_idx]);

    unique case (state_q)
      IDLE: begin
        if (i_frame_start && pending_q) begin
          pending_d = 1'b0;
          cnt_d     = '0;
          state_d   = COPY;
        end
      end
      COPY: begin
        active_w0_d[cnt_q] = shadow_w0_q[cnt_q];
        active_w1_d[cnt_q] = shadow_w1_q[cnt_q];
        cnt_d              = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_w0_q <= '{default: '0};
      shadow_w1_q <= '{default: '0};
      active_w0_q <= '{default: '0};
      active_w1_q <= '{default: '0};
      state_q     <= IDLE;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      sprite_q    <= '0;
    end else begin
      shadow_w0_q <= shadow_w0_d;
      shadow_w1_q <= shadow_w1_d;
      active_w0_q <= active_w0_d;
      active_w1_q <= active_w1_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      rd_valid_q  <= rd_valid_d;
      sprite_q    <= sprite_d;
    end
  end

  assign bus.o_sprite_struct = sprite_q;
  assign bus.o_rd_valid      = rd_valid_q;
  assign o_commit_pending    = pending_q;
  assign o_busy              = (state_q == COPY);

endmodule

// File: tb/tb_sprite_attr_table.sv
// Directed bench for sprite_attr_table: reset, write/commit, byte enables, out-of-range,
// writes and reads during copy, and reset in the middle of a copy.
module tb_sprite_attr_table;

  logic clk = 1'b0;
  logic rst_n;
  logic i_frame_start;
  logic o_commit_pending;
  logic o_busy;
  int   checks   = 0;
  int   failures = 0;
  int   n;

  sprite_attr_table_if #(.IDX_W(5), .ADDR_W(27)) bus ();

  sprite_attr_table #(
    .SPRITE_COUNT(32), .IDX_W(5), .ADDR_W(27), .BASE_ADDR(27'h100)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus.slave),
    .i_frame_start    (i_frame_start),
    .o_commit_pending (o_commit_pending),
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [26:0] addr, input logic [31:0] data, input logic [3:0] sel);
    bus.i_waddr   = addr;
    bus.i_wdata   = data;
    bus.i_wselect = sel;
    bus.i_wea     = 1'b1;
    tick();
    bus.i_wea     = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [4:0] idx, input logic [63:0] exp);
    bus.i_sprite_idx = idx;
    bus.i_rd_en      = 1'b1;
    tick();
    bus.i_rd_en      = 1'b0;
    chk({tag, "_vld"}, {63'h0, bus.o_rd_valid}, 64'h1);
    chk(tag, bus.o_sprite_struct, exp);
  endtask

  task automatic pulse_frame();
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (o_busy && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic commit(input string tag);
    int c;
    cpu_write(27'h200, 32'h1, 4'h1);
    pulse_frame();
    wait_idle(c);
    chk(tag, 64'(c), 64'd32);
  endtask

  initial begin
    rst_n = 1'b0;
    i_frame_start = 1'b0;
    bus.i_sprite_idx = '0;
    bus.i_rd_en = 1'b0;
    bus.i_wdata = '0;
    bus.i_wea = 1'b0;
    bus.i_wselect = '0;
    bus.i_waddr = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset values
    chk("rst_pending", {63'h0, o_commit_pending}, 64'h0);
    chk("rst_busy", {63'h0, o_busy}, 64'h0);
    chk("rst_vld", {63'h0, bus.o_rd_valid}, 64'h0);
    chk("rst_struct", bus.o_sprite_struct, 64'h0);
    read_chk("rst_rd3", 5'd3, 64'h0);
    tick();
    chk("idle_vld", {63'h0, bus.o_rd_valid}, 64'h0);

    // Write entry 5 and commit
    cpu_write(27'h128, 32'h0012_0034, 4'hF);
    cpu_write(27'h12C, 32'hABCD_0000, 4'hF);
    chk("pre_ctrl_pending", {63'h0, o_commit_pending}, 64'h0);
    read_chk("shadow_not_active", 5'd5, 64'h0);
    cpu_write(27'h200, 32'h1, 4'h1);
    chk("ctrl_pending", {63'h0, o_commit_pending}, 64'h1);
    pulse_frame();
    chk("commit_busy", {63'h0, o_busy}, 64'h1);
    chk("commit_pending_clr", {63'h0, o_commit_pending}, 64'h0);
    wait_idle(n);
    chk("busy_cycles", 64'(n), 64'd32);
    read_chk("rd5", 5'd5, 64'h0000_CDAB_0034_0012);
    read_chk("rd4", 5'd4, 64'h0);

    // Byte enables
    cpu_write(27'h100, 32'hFFFF_FFFF, 4'b0010);
    read_chk("be_nocommit", 5'd0, 64'h0);
    commit("be_commit");
    read_chk("be_rd0", 5'd0, 64'h0000_0000_FF00_0000);

    // Out-of-range writes and idle frame start
    cpu_write(27'h0FC, 32'hFFFF_FFFF, 4'hF);
    cpu_write(27'h204, 32'h1, 4'hF);
    chk("oor_pending", {63'h0, o_commit_pending}, 64'h0);
    pulse_frame();
    chk("nopend_busy", {63'h0, o_busy}, 64'h0);
    // Request coincident with frame start: pending set, no copy yet
    i_frame_start = 1'b1;
    cpu_write(27'h200, 32'h1, 4'h1);
    i_frame_start = 1'b0;
    chk("coinc_busy", {63'h0, o_busy}, 64'h0);
    chk("coinc_pending", {63'h0, o_commit_pending}, 64'h1);
    pulse_frame();
    wait_idle(n);
    chk("oor_cycles", 64'(n), 64'd32);
    read_chk("oor_rd0", 5'd0, 64'h0000_0000_FF00_0000);
    read_chk("oor_rd31", 5'd31, 64'h0);

    // Writes during copy; frame start at edge t, now in cycle t+1 (cnt=0)
    cpu_write(27'h200, 32'h1, 4'h1);
    pulse_frame();
    repeat (10) tick();
    cpu_write(27'h1A0, 32'h1111_2222, 4'hF);
    cpu_write(27'h110, 32'h3333_4444, 4'hF);
    repeat (8) tick();
    read_chk("rd20_old", 5'd20, 64'h0);
    read_chk("rd20_new", 5'd20, 64'h0000_0000_2222_1111);
    cpu_write(27'h200, 32'h1, 4'h1);
    chk("copy_req_pending", {63'h0, o_commit_pending}, 64'h1);
    pulse_frame();
    chk("fs_in_copy_busy", {63'h0, o_busy}, 64'h1);
    chk("fs_in_copy_pending", {63'h0, o_commit_pending}, 64'h1);
    wait_idle(n);
    chk("copy_idle", {63'h0, o_busy}, 64'h0);
    read_chk("rd2_old", 5'd2, 64'h0);
    read_chk("rd20_after", 5'd20, 64'h0000_0000_2222_1111);
    pulse_frame();
    wait_idle(n);
    chk("second_cycles", 64'(n), 64'd32);
    read_chk("rd2_new", 5'd2, 64'h0000_0000_4444_3333);

    // Reset mid-copy at cnt=7
    cpu_write(27'h200, 32'h1, 4'h1);
    pulse_frame();
    repeat (7) tick();
    chk("pre_rst_busy", {63'h0, o_busy}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'h0, o_busy}, 64'h0);
    chk("mid_rst_pending", {63'h0, o_commit_pending}, 64'h0);
    chk("mid_rst_struct", bus.o_sprite_struct, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    read_chk("post_rst_rd5", 5'd5, 64'h0);
    read_chk("post_rst_rd20", 5'd20, 64'h0);
    commit("post_rst_commit");
    read_chk("post_rst_shadow2", 5'd2, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
